paddle: RTL

Player paddle controller: turns raw up/down push-buttons into a clamped 4-bit paddle row position on the LED matrix. Sits upstream of `screen` (and of the ball/paddle collision logic), alongside `ball`, and is driven by the same 1 kHz game tick. Provides button synchronisation, tick-based debouncing, a single step on press, and auto-repeat while a button is held.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/debounce.sv | 48 ++++
 rtl/paddle.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: matrix geometry, paddle
// direction and paddle auto-repeat FSM states.
package pong_pkg;

  localparam int MATRIX_H   = 16;
  localparam int PADDLE_LEN = 3;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce.sv
// One push-button cleaner: 2-flop synchroniser followed by a tick-gated
// debouncer that only accepts a level held for DEBOUNCE consecutive ticks.
module debounce #(
  parameter int DEBOUNCE = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any agreeing tick throws away the partial count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (tick) begin
        if (r_sync2 != r_level) begin
          if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/paddle.sv
// Player paddle controller: debounced up/down buttons drive a saturating
// 4-bit paddle row with a single step on press and auto-repeat while held.
module paddle
  import pong_pkg::*;
#(
  parameter int HEIGHT       = MATRIX_H,
  parameter int LEN          = PADDLE_LEN,
  parameter int DEBOUNCE     = 5,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] y,
  output logic       moved
);

  localparam int         RCNT_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [3:0] Y_MAX  = 4'(HEIGHT - LEN);
  localparam logic [3:0] Y_INIT = 4'((HEIGHT - LEN) / 2);

  logic              w_up;
  logic              w_down;
  dir_t              w_dir;
  state_t            r_state;
  state_t            w_nextState;
  dir_t              r_dir;
  dir_t              w_nextDir;
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_nextRcnt;
  logic              w_step;
  logic [3:0]        r_y;
  logic [3:0]        w_nextY;
  logic              r_moved;

  debounce #(.DEBOUNCE(DEBOUNCE)) u_dbUp (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .i_raw   (btn_up),
    .o_level (w_up)
  );

  debounce #(.DEBOUNCE(DEBOUNCE)) u_dbDown (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .i_raw   (btn_down),
    .o_level (w_down)
  );

  always_comb begin
    w_dir = NONE;
    if (w_up && !w_down)      w_dir = UP;
    else if (!w_up && w_down) w_dir = DOWN;
  end

  // r_dir remembers the direction being repeated, so a reversal is seen as a
  // mismatch and drops back to IDLE without stepping.
  always_comb begin
    w_nextState = r_state;
    w_nextRcnt  = r_rcnt;
    w_nextDir   = r_dir;
    w_step      = 1'b0;
    if (tick) begin
      case (r_state)
        IDLE: begin
          if (w_dir != NONE) begin
            w_step      = 1'b1;
            w_nextState = DELAY;
            w_nextRcnt  = '0;
            w_nextDir   = w_dir;
          end
        end
        DELAY: begin
          if (w_dir != r_dir) begin
            w_nextState = IDLE;
            w_nextRcnt  = '0;
          end else if (r_rcnt == RCNT_W'(REPEAT_DELAY - 1)) begin
            w_step      = 1'b1;
            w_nextState = REPEAT;
            w_nextRcnt  = '0;
          end else begin
            w_nextRcnt = r_rcnt + RCNT_W'(1);
          end
        end
        REPEAT: begin
          if (w_dir != r_dir) begin
            w_nextState = IDLE;
            w_nextRcnt  = '0;
          end else if (r_rcnt == RCNT_W'(REPEAT_RATE - 1)) begin
            w_step     = 1'b1;
            w_nextRcnt = '0;
          end else begin
            w_nextRcnt = r_rcnt + RCNT_W'(1);
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextRcnt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_nextY = r_y;
    if (w_step) begin
      if (w_dir == UP && r_y != 4'd0)         w_nextY = r_y - 4'd1;
      else if (w_dir == DOWN && r_y != Y_MAX) w_nextY = r_y + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= NONE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_dir   <= w_nextDir;
      r_rcnt  <= w_nextRcnt;
    end
  end

  // A saturated step leaves y alone, so moved follows the actual change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y     <= Y_INIT;
      r_moved <= 1'b0;
    end else begin
      r_y     <= w_nextY;
      r_moved <= (w_nextY != r_y);
    end
  end

  assign y     = r_y;
  assign moved = r_moved;

endmodule
